// File: rtl/div_half_ctrl_if.sv
// Ratio request handshake between the clock-management register block and div_half_ctrl.
// master drives a ratio request; slave accepts it when req_valid && req_ready.
interface div_half_ctrl_if #(
  parameter int unsigned W = 8
);
  logic         req_valid;
  logic [W-1:0] req_n;
  logic         req_ready;

  modport master (output req_valid, output req_n, input req_ready);
  modport slave  (input req_valid, input req_n, output req_ready);
endinterface

// File: rtl/div_half_ctrl.sv
// Run-time controller for the half-integer (N/2) clock divider: accepts ratio requests
// and applies ratio changes / stops only on N-cycle frame boundaries for glitch-free switching.
module div_half_ctrl #(
  parameter int unsigned W         = 8,
  parameter int unsigned N_DEFAULT = 13,
  parameter int unsigned N_MIN     = 3,
  parameter int unsigned RST_CYC   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_enable,
  div_half_ctrl_if.slave req,
  output logic [W-1:0]   o_div_n,
  output logic           o_div_rst_n,
  output logic           o_div_active,
  output logic           o_frame_pulse,
  output logic           o_err_pulse,
  output logic           o_busy
);

  localparam int unsigned SW        = $clog2(RST_CYC) + 1;
  localparam logic [SW-1:0] SCNT_LAST = SW'(RST_CYC - 1);
  localparam logic [W-1:0]  N_RST     = W'(N_DEFAULT);
  localparam logic [W-1:0]  N_LO      = W'(N_MIN);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e        r_state;
  logic [W-1:0]  r_cnt;
  logic [SW-1:0] r_scnt;
  logic [W-1:0]  r_div_n;
  logic [W-1:0]  r_pend_n;
  logic          r_pend_flag;
  logic          r_div_rst_n;
  logic          r_div_active;
  logic          r_frame_pulse;
  logic          r_err_pulse;
  logic          r_busy;

  state_e        w_state_next;
  logic [W-1:0]  w_cnt_next;
  logic [SW-1:0] w_scnt_next;
  logic [W-1:0]  w_div_n_next;
  logic [W-1:0]  w_pend_n_next;
  logic          w_pend_flag_next;
  logic          w_err_next;
  logic          w_run_next;
  logic          w_frame_next;
  logic          w_ready;
  logic          w_fire;
  logic          w_legal;
  logic          w_frame_end;
  logic [W-1:0]  w_cnt_step;

  // Handshake readiness depends on state only; requests stall while starting or draining.
  assign w_ready       = (r_state == S_OFF) || (r_state == S_RUN);
  assign req.req_ready = w_ready;

  assign w_fire      = req.req_valid && w_ready;
  assign w_legal     = req.req_n[0] && (req.req_n >= N_LO);
  assign w_frame_end = (r_cnt == (r_div_n - W'(1)));
  assign w_cnt_step  = w_frame_end ? '0 : (r_cnt + W'(1));

  // Next-state and next-register values.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = '0;
    w_scnt_next      = '0;
    w_div_n_next     = r_div_n;
    w_pend_n_next    = r_pend_n;
    w_pend_flag_next = r_pend_flag;
    w_err_next       = w_fire && !w_legal;

    case (r_state)
      S_OFF: begin
        if (w_fire && w_legal) begin
          w_div_n_next = req.req_n;
        end
        if (i_enable) begin
          w_state_next = S_START;
        end
      end

      S_START: begin
        if (!i_enable) begin
          w_state_next = S_OFF;
        end else if (r_scnt == SCNT_LAST) begin
          w_state_next = S_RUN;
        end else begin
          w_scnt_next = r_scnt + SW'(1);
        end
      end

      S_RUN: begin
        w_cnt_next = w_cnt_step;
        if (w_fire && w_legal) begin
          w_pend_n_next    = req.req_n;
          w_pend_flag_next = 1'b1;
          w_state_next     = S_DRAIN;
        end
        if (!i_enable) begin
          w_state_next = S_DRAIN;
        end
      end

      S_DRAIN: begin
        w_cnt_next = w_cnt_step;
        // Leave only on the last cycle of a frame so no divided period is truncated.
        if (w_frame_end) begin
          if (r_pend_flag) begin
            w_div_n_next     = r_pend_n;
            w_pend_flag_next = 1'b0;
          end
          w_cnt_next   = '0;
          w_state_next = i_enable ? S_START : S_OFF;
        end
      end

      default: begin
        w_state_next = S_OFF;
      end
    endcase
  end

  assign w_run_next   = (w_state_next == S_RUN) || (w_state_next == S_DRAIN);
  assign w_frame_next = w_run_next && (w_cnt_next == (w_div_n_next - W'(1)));

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_OFF;
      r_cnt         <= '0;
      r_scnt        <= '0;
      r_div_n       <= N_RST;
      r_pend_n      <= N_RST;
      r_pend_flag   <= 1'b0;
      r_div_rst_n   <= 1'b0;
      r_div_active  <= 1'b0;
      r_frame_pulse <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_scnt        <= w_scnt_next;
      r_div_n       <= w_div_n_next;
      r_pend_n      <= w_pend_n_next;
      r_pend_flag   <= w_pend_flag_next;
      r_div_rst_n   <= w_run_next;
      r_div_active  <= w_run_next;
      r_frame_pulse <= w_frame_next;
      r_err_pulse   <= w_err_next;
      r_busy        <= (w_state_next == S_START) || (w_state_next == S_DRAIN);
    end
  end

  assign o_div_n       = r_div_n;
  assign o_div_rst_n   = r_div_rst_n;
  assign o_div_active  = r_div_active;
  assign o_frame_pulse = r_frame_pulse;
  assign o_err_pulse   = r_err_pulse;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_div_half_ctrl.sv
// Self-checking bench for div_half_ctrl: directed scenarios plus random traffic,
// compared every cycle against a frame-level behavioural model.
module tb_div_half_ctrl;

  localparam int RST_CYC = 2;
  localparam int N_MIN   = 3;
  localparam int N_DEF   = 13;
  localparam logic [13:0] RESET_VEC = {8'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_enable;
  logic [7:0] o_div_n;
  logic       o_div_rst_n;
  logic       o_div_active;
  logic       o_frame_pulse;
  logic       o_err_pulse;
  logic       o_busy;

  div_half_ctrl_if #(.W(8)) bus ();

  div_half_ctrl #(
    .W(8), .N_DEFAULT(N_DEF), .N_MIN(N_MIN), .RST_CYC(RST_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (i_enable),
    .req          (bus),
    .o_div_n      (o_div_n),
    .o_div_rst_n  (o_div_rst_n),
    .o_div_active (o_div_active),
    .o_frame_pulse(o_frame_pulse),
    .o_err_pulse  (o_err_pulse),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 = stopped, 1 = divider held in reset, 2 = running.
  int m_mode, m_rst_left, m_pos, m_n, m_pend;
  bit m_leaving, m_has_pend, m_err;

  function automatic void model_reset();
    m_mode = 0; m_rst_left = 0; m_pos = 0; m_n = N_DEF; m_pend = N_DEF;
    m_leaving = 0; m_has_pend = 0; m_err = 0;
  endfunction

  function automatic bit m_ready();
    return (m_mode == 0) || (m_mode == 2 && !m_leaving);
  endfunction

  function automatic void model_step(input bit en, input bit v, input int n);
    bit acc, legal, eof;
    acc   = v && m_ready();
    legal = (n % 2 == 1) && (n >= N_MIN);
    m_err = acc && !legal;
    case (m_mode)
      0: begin
        if (acc && legal) m_n = n;
        if (en) begin m_mode = 1; m_rst_left = RST_CYC; end
      end
      1: begin
        if (!en) m_mode = 0;
        else begin
          m_rst_left--;
          if (m_rst_left == 0) begin m_mode = 2; m_pos = 0; m_leaving = 0; end
        end
      end
      default: begin
        eof   = (m_pos == m_n - 1);
        m_pos = (m_pos + 1) % m_n;
        if (m_leaving) begin
          if (eof) begin
            if (m_has_pend) begin m_n = m_pend; m_has_pend = 0; end
            m_leaving = 0; m_mode = en ? 1 : 0; m_rst_left = RST_CYC; m_pos = 0;
          end
        end else begin
          if (acc && legal) begin m_pend = n; m_has_pend = 1; m_leaving = 1; end
          if (!en) m_leaving = 1;
        end
      end
    endcase
  endfunction

  function automatic logic [13:0] exp_vec();
    return {8'(m_n), m_mode == 2, m_mode == 2, (m_mode == 2) && (m_pos == m_n - 1),
            m_err, (m_mode == 1) || (m_mode == 2 && m_leaving), m_ready()};
  endfunction

  function automatic logic [13:0] obs_vec();
    return {o_div_n, o_div_rst_n, o_div_active, o_frame_pulse, o_err_pulse, o_busy, bus.req_ready};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic cyc(input bit en, input bit v, input logic [7:0] n);
    i_enable = en; bus.req_valid = v; bus.req_n = n;
    @(posedge clk);
    model_step(en, v, int'(n));
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_enable = 1'b0; bus.req_valid = 1'b0; bus.req_n = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_vec() !== RESET_VEC) begin
      n_bad++; $display("FAIL reset_values: got %h want %h", obs_vec(), RESET_VEC);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_start_run();
    int first_act, first_pulse, second_pulse;
    first_act = -1; first_pulse = -1; second_pulse = -1;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 8'd0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL start_idle k=%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
    end
    for (int k = 1; k <= 40; k++) begin
      cyc(1'b1, 1'b0, 8'd0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL start_run k=%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      if (o_div_active === 1'b1 && first_act < 0) first_act = k;
      if (o_frame_pulse === 1'b1) begin
        if (first_pulse < 0) first_pulse = k;
        else if (second_pulse < 0) second_pulse = k;
      end
    end
    n_cmp++;
    if (first_act != 1 + RST_CYC || first_pulse != first_act + 12 || second_pulse != first_pulse + 13) begin
      n_bad++;
      $display("FAIL start_timing: active@%0d pulse@%0d,%0d want 3,15,28", first_act, first_pulse, second_pulse);
    end
  endtask

  task automatic test_illegal();
    int n_err;
    n_err = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) cyc(1'b1, 1'b1, 8'd8);
      else if (k == 4) cyc(1'b1, 1'b1, 8'd1);
      else cyc(1'b1, 1'b0, 8'd0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL illegal k=%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      if (o_err_pulse === 1'b1) n_err++;
    end
    n_cmp++;
    if (n_err != 2 || o_div_n !== 8'd13 || o_div_active !== 1'b1) begin
      n_bad++; $display("FAIL illegal_summary: errs=%0d div_n=%0d active=%b want 2,13,1", n_err, o_div_n, o_div_active);
    end
  endtask

  task automatic test_stop();
    bit found;
    int n_act;
    bit last_frame;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_mode == 2 && !m_leaving && m_pos == 4) found = 1;
      else cyc(1'b1, 1'b0, 8'd0);
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL stop_wait: got timeout want cnt=4"); end
    cyc(1'b0, 1'b0, 8'd0);
    n_act = 0; last_frame = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_div_active === 1'b1) begin n_act++; last_frame = o_frame_pulse; end
      cyc(1'b0, 1'b0, 8'd0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL stop i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (n_act != 8 || last_frame !== 1'b1 || o_div_rst_n !== 1'b0) begin
      n_bad++; $display("FAIL stop_drain: act=%0d frame=%b rst_n=%b want 8,1,0", n_act, last_frame, o_div_rst_n);
    end
  endtask

  task automatic test_switch();
    int pulses[$];
    int k_acc;
    for (int k = 0; k < 10 + int'($urandom_range(0, 12)); k++) cyc(1'b1, 1'b0, 8'd0);
    n_cmp++;
    if (m_mode != 2 || o_div_n !== 8'd13) begin
      n_bad++; $display("FAIL switch_pre: got div_n=%0d want 13 running", o_div_n);
    end
    cyc(1'b1, 1'b1, 8'd7);
    k_acc = 0;
    for (int k = 1; k <= 60; k++) begin
      cyc(1'b1, 1'b0, 8'd0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL switch k=%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      if (o_div_rst_n === 1'b0 && k_acc == 0) k_acc = k;
      if (o_frame_pulse === 1'b1) pulses.push_back(k);
    end
    n_cmp++;
    if (k_acc < 1 || k_acc > 14 || pulses.size() < 3 ||
        pulses[pulses.size()-1] - pulses[pulses.size()-2] != 7) begin
      n_bad++; $display("FAIL switch_timing: rst_fall@%0d npulse=%0d want <=14 and 7-cycle frames", k_acc, pulses.size());
    end
  endtask

  task automatic test_off_request();
    for (int k = 0; k < 25; k++) cyc(1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 8'd9);
    n_cmp++;
    if (o_div_n !== 8'd9 || o_div_rst_n !== 1'b0 || exp_vec() !== obs_vec()) begin
      n_bad++; $display("FAIL off_request: got div_n=%0d rst_n=%b want 9,0", o_div_n, o_div_rst_n);
    end
    for (int k = 1; k <= 25; k++) begin
      cyc(1'b1, 1'b0, 8'd0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL off_run k=%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_drain();
    cyc(1'b1, 1'b1, 8'd5);
    cyc(1'b1, 1'b0, 8'd0);
    n_cmp++;
    if (o_busy !== 1'b1 || bus.req_ready !== 1'b0) begin
      n_bad++; $display("FAIL drain_state: got busy=%b ready=%b want 1,0", o_busy, bus.req_ready);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_vec() !== RESET_VEC) begin
      n_bad++; $display("FAIL reset_mid: got %h want %h", obs_vec(), RESET_VEC);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, 1'b0, 8'd0);
      n_cmp++;
      if (obs_vec() !== exp_vec() || o_div_n !== 8'd13) begin
        n_bad++; $display("FAIL reset_after k=%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_simultaneous();
    bit found;
    int n_act;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_mode == 2 && !m_leaving && m_pos == m_n - 1) found = 1;
      else cyc(1'b1, 1'b0, 8'd0);
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL simul_wait: got timeout want frame end"); end
    cyc(1'b1, 1'b1, 8'd5);
    n_act = 0;
    for (int i = 0; i < 30; i++) begin
      if (o_div_active === 1'b1 && o_div_n === 8'd13) n_act++;
      cyc(1'b1, 1'b0, 8'd0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL simul_eof i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (n_act != 13 || o_div_n !== 8'd5) begin
      n_bad++; $display("FAIL simul_full_frame: act=%0d div_n=%0d want 13,5", n_act, o_div_n);
    end
    cyc(1'b0, 1'b1, 8'd7);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b0, 8'd0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL simul_stop i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (o_div_n !== 8'd7 || o_div_rst_n !== 1'b0 || o_busy !== 1'b0) begin
      n_bad++; $display("FAIL simul_stop_end: div_n=%0d rst_n=%b busy=%b want 7,0,0", o_div_n, o_div_rst_n, o_busy);
    end
  endtask

  task automatic test_random();
    bit en, v;
    logic [7:0] n;
    en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      v = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) < 7) n = 8'(2 * $urandom_range(1, 10) + 1);
      else n = 8'($urandom_range(0, 20));
      cyc(en, v, n);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random k=%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_run();
    test_illegal();
    test_stop();
    test_switch();
    test_off_request();
    test_reset_drain();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_half_ctrl.md
Name: div_half_ctrl

Overview:
- Run-time controller for the half-integer clock divider (divide by N/2, odd N).
- Accepts divide-ratio requests over a valid/ready handshake and drives the divider's ratio input and local reset.
- Ratio changes and stops take effect only on a frame boundary, so divided-clock switchover is glitch-free. One frame is N input clocks, which is two output periods.
- Sits between the clock-management register block and the divider instance.

Parameters:
- W, 8: width of the ratio value and the frame counter.
- N_DEFAULT, 13: ratio loaded at reset. Must be odd and ≥ N_MIN.
- N_MIN, 3: smallest legal ratio.
- RST_CYC, 2: number of cycles div_rst_n is held low before each (re)start. Must be ≥ 1.

Ports:
- clk  in  1  system clock; also the divider's source clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; 1 = divider should run
- req_valid  in  1  ratio request valid
- req_n  in  W  requested ratio N
- req_ready  out  1  request accepted when req_valid && req_ready
- div_n  out  W  ratio presented to the divider
- div_rst_n  out  1  divider reset, active low
- div_active  out  1  divider running with div_n
- frame_pulse  out  1  one-cycle pulse on the last clk of each N-cycle frame
- err_pulse  out  1  one-cycle pulse: illegal ratio request dropped
- busy  out  1  state is START or DRAIN

Behaviour:
- Reset (async, rst_n=0) sets:
  - state OFF; div_n = N_DEFAULT; pend_n = N_DEFAULT; pend_flag = 0
  - div_rst_n = 0; div_active = 0; frame_pulse = 0; err_pulse = 0
  - req_ready = 1; frame counter cnt = 0; start counter = 0
- All outputs are registered. No combinational path from input to output, except that req_ready is a function of state only.
- Legal ratio: req_n is odd and req_n ≥ N_MIN.
  - Illegal request: the handshake still completes; err_pulse = 1 on the next cycle; div_n and pend_n are unchanged.
- States:
  - OFF: div_rst_n = 0, div_active = 0, req_ready = 1.
    - Legal request: div_n ← req_n on the next cycle.
    - enable = 1 → START.
  - START: div_rst_n = 0 for exactly RST_CYC cycles, req_ready = 0.
    - enable = 0 during START → OFF immediately.
    - Otherwise → RUN with cnt = 0.
  - RUN: div_rst_n = 1, div_active = 1, req_ready = 1.
    - cnt counts 0 … div_n−1 and wraps.
    - frame_pulse = 1 on the cycle where cnt == div_n−1.
    - Legal request: pend_n ← req_n, pend_flag = 1, → DRAIN.
    - enable = 0 → DRAIN (stop pending).
  - DRAIN: identical to RUN (divider keeps running, cnt keeps counting), except req_ready = 0.
    - Requests stall; enable changes are sampled continuously.
    - At frame end (cnt == div_n−1, with frame_pulse asserted that cycle):
      - if pend_flag: div_n ← pend_n and pend_flag ← 0;
      - then → START if enable = 1, else → OFF.
- Simultaneous events:
  - Request accepted in RUN on the same cycle enable falls: at frame end div_n takes the new value and the state goes to OFF.
  - Request accepted in the same cycle cnt == div_n−1: treat as the frame end already passed. DRAIN waits for the next full frame.
  - enable re-asserted in DRAIN before frame end: restart via START, never straight to RUN.
- Switch latency, measured from the accepting edge to div_rst_n falling: ≤ div_n cycles.
  - div_rst_n then stays low for RST_CYC cycles.
  - The new ratio is active on the first RUN cycle.
- Reset mid-operation: everything returns to reset values asynchronously. Any pending request is lost.
- cnt is W bits and never exceeds div_n−1; no overflow is possible for a legal div_n.

Test Plan:
- Reset, enable = 1 at cycle 5 → div_rst_n low for cycles 6–7, div_active = 1 from cycle 8, div_n = 13, frame_pulse every 13 cycles.
- While running, request req_n = 7 → req_ready = 0 until the 13-cycle frame completes; then 2 reset cycles; then frame_pulse every 7 cycles. No frame truncated.
- Request req_n = 8, then req_n = 1 → err_pulse once for each; div_n stays 13; no restart.
- enable = 0 in the middle of a frame (cnt = 4, div_n = 13) → runs 8 more cycles, frame_pulse fires, then OFF with div_rst_n = 0.
- In OFF, request 9, then enable = 1 → START, then RUN with div_n = 9.
- Assert rst_n low for 1 cycle during DRAIN with pending 5 → immediate OFF values, div_n = 13, pend_flag cleared.
